fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 105 ++++++++++
 tb/tb_fetch_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-cycle imem requests and
// fills the IF/ID register, redirecting on taken branches and halting on misaligned targets.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [11:0] branch_offset,
    input  logic [31:0] branch_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instr,
    output logic        flush,
    output logic        misalign_err
);

    typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] ipc_q, ipc_d;
    logic [31:0] instr_q, instr_d;
    logic        err_q, err_d;

    logic [31:0] target;
    logic        br_fetch;
    logic        transfer;

    assign target   = branch_pc + {{19{branch_offset[11]}}, branch_offset, 1'b0};
    assign br_fetch = (state_q == FETCH) && branch_taken;

    // Gated by rst_n so nothing escapes while reset is being sampled.
    assign imem_req  = rst_n && (state_q == FETCH) && !stall && !branch_taken;
    assign flush     = rst_n && br_fetch;
    assign transfer  = imem_req && imem_ready;
    assign imem_addr = pc_q;

    assign ifid_valid   = valid_q;
    assign ifid_pc      = ipc_q;
    assign ifid_instr   = instr_q;
    assign misalign_err = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            ipc_q   <= '0;
            instr_q <= NOP_INSTR;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            ipc_q   <= ipc_d;
            instr_q <= instr_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        ipc_d   = ipc_q;
        instr_d = instr_q;
        err_d   = err_q;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                // Branch handling outranks stall and memory handshake.
                if (br_fetch && (target[1:0] == 2'b00)) begin
                    pc_d    = target;
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                end else if (br_fetch) begin
                    state_d = HALT;
                    err_d   = 1'b1;
                    valid_d = 1'b0;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (transfer) begin
                    valid_d = 1'b1;
                    ipc_d   = pc_q;
                    instr_d = imem_rdata;
                    pc_d    = pc_q + 32'd4;
                end else begin
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                end
            end
            HALT:    valid_d = 1'b0;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model of the fetch stage.
module tb_fetch_unit;

    localparam logic [31:0] K   = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n, stall, branch_taken, imem_ready;
    logic [11:0] branch_offset;
    logic [31:0] branch_pc, imem_rdata, rnd_rdata;
    logic        xor_mode;
    logic        imem_req, ifid_valid, flush, misalign_err;
    logic [31:0] imem_addr, ifid_pc, ifid_instr;
    logic        w_req, w_valid, w_flush, w_err;
    logic [31:0] w_addr, w_ipc, w_instr;

    int n_pass = 0;
    int n_total = 0;

    // Behavioural model: 0 = just out of reset, 1 = fetching, 2 = halted
    int          m_phase;
    logic [31:0] m_pc, m_ipc, m_instr;
    logic        m_valid, m_err;

    always #5 clk = ~clk;

    assign imem_rdata = xor_mode ? (imem_addr ^ K) : rnd_rdata;

    fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
        .branch_offset(branch_offset), .branch_pc(branch_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .ifid_valid(ifid_valid), .ifid_pc(ifid_pc),
        .ifid_instr(ifid_instr), .flush(flush), .misalign_err(misalign_err)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
        .branch_offset(branch_offset), .branch_pc(branch_pc),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .ifid_valid(w_valid), .ifid_pc(w_ipc),
        .ifid_instr(w_instr), .flush(w_flush), .misalign_err(w_err)
    );

    function automatic logic exp_req();
        return rst_n && m_phase == 1 && !stall && !branch_taken;
    endfunction

    function automatic logic exp_flush();
        return rst_n && m_phase == 1 && branch_taken;
    endfunction

    task automatic model_edge();
        logic [31:0] tgt;
        logic [31:0] data;
        tgt  = branch_pc + 32'($signed(branch_offset) * 2);
        data = xor_mode ? (m_pc ^ K) : rnd_rdata;
        if (!rst_n) begin
            m_phase = 0; m_pc = 32'h0; m_valid = 0; m_ipc = 0; m_instr = NOP; m_err = 0;
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (branch_taken) begin
                m_valid = 0;
                if (tgt % 4 == 0) begin
                    m_pc = tgt; m_instr = NOP;
                end else begin
                    m_phase = 2; m_err = 1;
                end
            end else if (!stall) begin
                if (imem_ready) begin
                    m_valid = 1; m_ipc = m_pc; m_instr = data; m_pc = m_pc + 4;
                end else begin
                    m_valid = 0; m_instr = NOP;
                end
            end
        end
    endtask

    // Advance one clock: model follows the edge, then settle at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(input logic r, input logic s, input logic bt, input logic rdy,
                         input logic [31:0] bpc, input logic [11:0] off);
        rst_n = r; stall = s; branch_taken = bt; imem_ready = rdy;
        branch_pc = bpc; branch_offset = off;
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 1, 32'h0, 12'h0);
        tick();
        drive(1, 0, 0, 1, 32'h0, 12'h0);
    endtask

    task automatic test_reset();
        xor_mode = 1;
        drive(0, 1, 1, 1, 32'h10, 12'hFFE);
        tick();
        n_total++; if (imem_req !== 1'b0) $display("FAIL reset_req got=%0b exp=0", imem_req); else n_pass++;
        n_total++; if (flush !== 1'b0) $display("FAIL reset_flush got=%0b exp=0", flush); else n_pass++;
        drive(1, 0, 0, 1, 32'h0, 12'h0);
        n_total++; if (imem_req !== 1'b0) $display("FAIL idle_req got=%0b exp=0", imem_req); else n_pass++;
        n_total++; if (imem_addr !== 32'h0) $display("FAIL reset_addr got=%h exp=0", imem_addr); else n_pass++;
        n_total++; if (ifid_valid !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", ifid_valid); else n_pass++;
        n_total++; if (ifid_pc !== 32'h0) $display("FAIL reset_ifid_pc got=%h exp=0", ifid_pc); else n_pass++;
        n_total++; if (ifid_instr !== NOP) $display("FAIL reset_instr got=%h exp=%h", ifid_instr, NOP); else n_pass++;
        n_total++; if (misalign_err !== 1'b0) $display("FAIL reset_err got=%0b exp=0", misalign_err); else n_pass++;
    endtask

    task automatic test_startup();
        tick();
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL start_fetch0 req=%0b addr=%h exp req=1 addr=0", imem_req, imem_addr); else n_pass++;
        tick();
        n_total++; if (imem_addr !== 32'h4) $display("FAIL start_addr4 got=%h exp=4", imem_addr); else n_pass++;
        n_total++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h0 || ifid_instr !== K) $display("FAIL start_ifid0 v=%0b pc=%h instr=%h exp v=1 pc=0 instr=%h", ifid_valid, ifid_pc, ifid_instr, K); else n_pass++;
        tick();
        n_total++; if (imem_addr !== 32'h8) $display("FAIL start_addr8 got=%h exp=8", imem_addr); else n_pass++;
        n_total++; if (ifid_pc !== 32'h4 || ifid_instr !== (K ^ 32'h4)) $display("FAIL start_ifid4 pc=%h instr=%h exp pc=4 instr=%h", ifid_pc, ifid_instr, K ^ 32'h4); else n_pass++;
    endtask

    task automatic test_stall();
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 0, 1, 32'h0, 12'h0);
            n_total++; if (imem_req !== 1'b0 || imem_addr !== 32'h8 || ifid_pc !== 32'h4 || ifid_valid !== 1'b1)
                $display("FAIL stall_hold req=%0b addr=%h ifid_pc=%h v=%0b exp req=0 addr=8 ifid_pc=4 v=1", imem_req, imem_addr, ifid_pc, ifid_valid); else n_pass++;
            tick();
        end
        drive(1, 0, 0, 1, 32'h0, 12'h0);
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) $display("FAIL stall_resume req=%0b addr=%h exp req=1 addr=8", imem_req, imem_addr); else n_pass++;
        tick();
        n_total++; if (ifid_pc !== 32'h8 || imem_addr !== 32'hC) $display("FAIL stall_after ifid_pc=%h addr=%h exp 8 c", ifid_pc, imem_addr); else n_pass++;
    endtask

    task automatic test_branch();
        drive(1, 0, 1, 1, 32'h10, 12'hFFE);
        n_total++; if (flush !== 1'b1 || imem_req !== 1'b0) $display("FAIL br_flush flush=%0b req=%0b exp 1 0", flush, imem_req); else n_pass++;
        tick();
        drive(1, 0, 0, 1, 32'h0, 12'h0);
        n_total++; if (imem_addr !== 32'hC || ifid_valid !== 1'b0 || ifid_instr !== NOP || flush !== 1'b0)
            $display("FAIL br_target addr=%h v=%0b instr=%h flush=%0b exp c 0 %h 0", imem_addr, ifid_valid, ifid_instr, flush, NOP); else n_pass++;
        tick();
        n_total++; if (imem_addr !== 32'h10) $display("FAIL br_refetch addr=%h exp=10", imem_addr); else n_pass++;
        drive(1, 1, 1, 1, 32'h10, 12'hFFE);
        n_total++; if (flush !== 1'b1) $display("FAIL br_stall_flush got=%0b exp=1", flush); else n_pass++;
        tick();
        drive(1, 0, 0, 0, 32'h0, 12'h0);
        n_total++; if (imem_addr !== 32'hC || ifid_valid !== 1'b0) $display("FAIL br_stall_target addr=%h v=%0b exp c 0", imem_addr, ifid_valid); else n_pass++;
        tick();
        n_total++; if (ifid_valid !== 1'b0 || ifid_instr !== NOP || imem_addr !== 32'hC) $display("FAIL bubble v=%0b instr=%h addr=%h exp 0 %h c", ifid_valid, ifid_instr, imem_addr, NOP); else n_pass++;
    endtask

    task automatic test_misalign();
        drive(1, 0, 1, 1, 32'h10, 12'h003);
        n_total++; if (flush !== 1'b1) $display("FAIL mis_flush got=%0b exp=1", flush); else n_pass++;
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 1'($urandom), 1, 32'h10, 12'hFFE);
            n_total++; if (misalign_err !== 1'b1 || imem_req !== 1'b0 || ifid_valid !== 1'b0 || flush !== 1'b0 || imem_addr !== 32'hC)
                $display("FAIL halt err=%0b req=%0b v=%0b flush=%0b addr=%h exp 1 0 0 0 c", misalign_err, imem_req, ifid_valid, flush, imem_addr); else n_pass++;
            tick();
        end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        tick(); tick(); tick();
        n_total++; if (ifid_valid !== 1'b1) $display("FAIL mid_pre_valid got=%0b exp=1", ifid_valid); else n_pass++;
        drive(0, 0, 0, 1, 32'h0, 12'h0);
        tick();
        drive(1, 0, 0, 1, 32'h0, 12'h0);
        n_total++; if (ifid_valid !== 1'b0 || ifid_instr !== NOP || imem_addr !== 32'h0 || imem_req !== 1'b0 || misalign_err !== 1'b0)
            $display("FAIL mid_reset v=%0b instr=%h addr=%h req=%0b err=%0b exp 0 %h 0 0 0", ifid_valid, ifid_instr, imem_addr, imem_req, misalign_err, NOP); else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        n_total++; if (w_addr !== 32'hFFFF_FFFC || w_req !== 1'b0) $display("FAIL wrap_idle addr=%h req=%0b exp fffffffc 0", w_addr, w_req); else n_pass++;
        tick();
        n_total++; if (w_addr !== 32'hFFFF_FFFC || w_req !== 1'b1) $display("FAIL wrap_fetch addr=%h req=%0b exp fffffffc 1", w_addr, w_req); else n_pass++;
        tick();
        n_total++; if (w_addr !== 32'h0 || w_ipc !== 32'hFFFF_FFFC || w_valid !== 1'b1) $display("FAIL wrap_next addr=%h ifid_pc=%h v=%0b exp 0 fffffffc 1", w_addr, w_ipc, w_valid); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] bpc;
        logic [11:0] off;
        int halted = 0;
        xor_mode = 0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bpc = $urandom;
            if ($urandom_range(0, 7) != 0) bpc[1:0] = 2'b00;
            off = 12'($urandom);
            if ($urandom_range(0, 5) != 0) off[0] = 1'b0;
            rnd_rdata = $urandom;
            halted = (m_phase == 2) ? halted + 1 : 0;
            drive(!(($urandom_range(0, 49) == 0) || halted > 5), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7, bpc, off);
            n_total++; if (imem_req !== exp_req()) $display("FAIL rnd_req cyc=%0d got=%0b exp=%0b", i, imem_req, exp_req()); else n_pass++;
            n_total++; if (flush !== exp_flush()) $display("FAIL rnd_flush cyc=%0d got=%0b exp=%0b", i, flush, exp_flush()); else n_pass++;
            n_total++; if (imem_addr !== m_pc) $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", i, imem_addr, m_pc); else n_pass++;
            n_total++; if (ifid_valid !== m_valid) $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", i, ifid_valid, m_valid); else n_pass++;
            n_total++; if (ifid_pc !== m_ipc) $display("FAIL rnd_ifid_pc cyc=%0d got=%h exp=%h", i, ifid_pc, m_ipc); else n_pass++;
            n_total++; if (m_valid && ifid_instr !== m_instr) $display("FAIL rnd_instr cyc=%0d got=%h exp=%h", i, ifid_instr, m_instr); else n_pass++;
            n_total++; if (misalign_err !== m_err) $display("FAIL rnd_err cyc=%0d got=%0b exp=%0b", i, misalign_err, m_err); else n_pass++;
            tick();
        end
    endtask

    initial begin
        xor_mode = 1; rnd_rdata = '0;
        m_phase = 0; m_pc = '0; m_valid = 0; m_ipc = '0; m_instr = NOP; m_err = 0;
        test_reset();
        test_startup();
        test_stall();
        test_branch();
        test_misalign();
        test_reset_midrun();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
